// File: rtl/mem_loader.sv
// Framed byte-stream memory loader: owns the memory write port while a frame
// is in progress, otherwise passes the CPU bus straight through.
module mem_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TMO_W          = 20
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  input  logic [15:0] CpuAddress,
  input  logic        CpuWE,
  input  logic [7:0]  CpuDataIn,
  output logic [15:0] MemAddress,
  output logic        MemWE,
  output logic [7:0]  MemDataIn,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  typedef enum logic [2:0] {IDLE, ALO, AHI, LLO, LHI, DATA, CHECK, DONE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_t           state_r, state_s;
  logic [15:0]      addr_r, addr_s, len_r, len_s, waddr_r, waddr_s;
  logic [7:0]       csum_r, csum_s, wdata_r, wdata_s;
  logic [TMO_W-1:0] tmo_r, tmo_s;
  logic             wr_r, wr_s, error_r, error_s;
  logic             accept_s, tmo_hit_s;

  assign RxReady   = RST_N && (state_r != DONE);
  assign accept_s  = RxValid && RxReady;
  assign tmo_hit_s = (tmo_r == TMO_LAST);

  assign CpuHold    = (state_r != IDLE);
  assign Done       = (state_r == DONE);
  assign Error      = error_r;
  assign MemWE      = CpuHold ? wr_r    : CpuWE;
  assign MemAddress = CpuHold ? waddr_r : CpuAddress;
  assign MemDataIn  = CpuHold ? wdata_r : CpuDataIn;

  // Next-state and datapath update for the frame parser.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    len_s   = len_r;
    csum_s  = csum_r;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    wr_s    = 1'b0;
    tmo_s   = '0;
    error_s = error_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (RxData == SYNC_BYTE)) begin
          state_s = ALO;
          error_s = 1'b0;
          addr_s  = 16'h0000;
          len_s   = 16'h0000;
          csum_s  = 8'h00;
        end else begin
          state_s = IDLE;
        end
      end
      DONE: state_s = IDLE;
      default: begin
        if (accept_s) begin
          case (state_r)
            ALO: begin
              addr_s  = {addr_r[15:8], RxData};
              state_s = AHI;
            end
            AHI: begin
              addr_s  = {RxData, addr_r[7:0]};
              state_s = LLO;
            end
            LLO: begin
              len_s   = {len_r[15:8], RxData};
              state_s = LHI;
            end
            LHI: begin
              len_s   = {RxData, len_r[7:0]};
              state_s = ({RxData, len_r[7:0]} == 16'h0000) ? CHECK : DATA;
            end
            DATA: begin
              wr_s    = 1'b1;
              waddr_s = addr_r;
              wdata_s = RxData;
              addr_s  = addr_r + 16'h0001;
              len_s   = len_r - 16'h0001;
              csum_s  = csum_r ^ RxData;
              state_s = (len_r == 16'h0001) ? CHECK : DATA;
            end
            CHECK: begin
              error_s = error_r | (RxData != csum_r);
              state_s = DONE;
            end
            default: state_s = IDLE;
          endcase
        end else if (tmo_hit_s) begin
          // Abort straight to IDLE; a write registered last cycle still lands now.
          error_s = 1'b1;
          state_s = IDLE;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_r  <= 16'h0000;
      len_r   <= 16'h0000;
      csum_r  <= 8'h00;
      waddr_r <= 16'h0000;
      wdata_r <= 8'h00;
      wr_r    <= 1'b0;
      tmo_r   <= '0;
      error_r <= 1'b0;
    end else begin
      addr_r  <= addr_s;
      len_r   <= len_s;
      csum_r  <= csum_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
      wr_r    <= wr_s;
      tmo_r   <= tmo_s;
      error_r <= error_s;
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: per-cycle vector table for whole frames,
// plus hand-written timeout and mid-frame reset sequences.
module tb_mem_loader;

  localparam int T = 50;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic        RxValid = 1'b0;
  logic        RxReady;
  logic [15:0] CpuAddress = 16'h1234;
  logic        CpuWE = 1'b0;
  logic [7:0]  CpuDataIn = 8'h5A;
  logic [15:0] MemAddress;
  logic        MemWE;
  logic [7:0]  MemDataIn;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;

  mem_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T), .TMO_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .CpuAddress(CpuAddress), .CpuWE(CpuWE), .CpuDataIn(CpuDataIn),
    .MemAddress(MemAddress), .MemWE(MemWE), .MemDataIn(MemDataIn),
    .CpuHold(CpuHold), .Done(Done), .Error(Error)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        cwe;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        hold;
    logic        done;
    logic        err;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic cwe, logic we, logic [15:0] a,
                              logic [7:0] di, logic h, logic dn, logic e, logic r);
    vec_t x;
    x.v = v; x.d = d; x.cwe = cwe; x.we = we; x.addr = a; x.din = di;
    x.hold = h; x.done = dn; x.err = e; x.rdy = r;
    return x;
  endfunction

  // Idle cycle: CPU bus passes through (address 1234, data 5A).
  function automatic vec_t idl(logic v, logic [7:0] d, logic cwe, logic e);
    return mk(v, d, cwe, cwe, 16'h1234, 8'h5A, 1'b0, 1'b0, e, 1'b1);
  endfunction

  // In-frame cycle with no loader write; CpuWE driven high and must be blocked.
  function automatic vec_t frm(logic [7:0] d, logic e);
    return mk(1'b1, d, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, e, 1'b1);
  endfunction

  function automatic vec_t wrc(logic [7:0] d, logic [15:0] a, logic [7:0] di, logic e);
    return mk(1'b1, d, 1'b1, 1'b1, a, di, 1'b1, 1'b0, e, 1'b1);
  endfunction

  function automatic vec_t dne(logic e);
    return mk(1'b1, 8'h77, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, e, 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RxValid = 1'b1;
    RxData  = b;
    CpuWE   = 1'b0;
  endtask

  logic [7:0] t4[6] = '{8'hA5, 8'h00, 8'h02, 8'h05, 8'h00, 8'h01};
  logic [7:0] t5[7] = '{8'hA5, 8'h00, 8'h01, 8'h04, 8'h00, 8'hD1, 8'hD2};

  initial begin
    logic bus;
    int   wcnt;
    int   dcnt;

    #1;
    chk("reset", {RxReady, CpuHold, Done, Error, MemWE, MemAddress, MemDataIn},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h5A});
    @(negedge CLK);
    RST_N = 1'b1;

    // Test 1: good 3-byte frame at 0300, DONE ignores a presented byte.
    tbl.push_back(idl(1'b1, 8'hA5, 1'b0, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h03, 1'b0));
    tbl.push_back(frm(8'h03, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'hA9, 1'b0));
    tbl.push_back(wrc(8'h19, 16'h0300, 8'hA9, 1'b0));
    tbl.push_back(wrc(8'h00, 16'h0301, 8'h19, 1'b0));
    tbl.push_back(wrc(8'hB0, 16'h0302, 8'h00, 1'b0));
    tbl.push_back(dne(1'b0));
    tbl.push_back(idl(1'b1, 8'h77, 1'b1, 1'b0));
    // Test 2: bad checksum sets Error; next SYNC clears it, then an empty frame.
    tbl.push_back(idl(1'b1, 8'hA5, 1'b0, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h03, 1'b0));
    tbl.push_back(frm(8'h03, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'hA9, 1'b0));
    tbl.push_back(wrc(8'h19, 16'h0300, 8'hA9, 1'b0));
    tbl.push_back(wrc(8'h00, 16'h0301, 8'h19, 1'b0));
    tbl.push_back(wrc(8'h00, 16'h0302, 8'h00, 1'b0));
    tbl.push_back(dne(1'b1));
    tbl.push_back(idl(1'b0, 8'h00, 1'b0, 1'b1));
    tbl.push_back(idl(1'b1, 8'hA5, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(dne(1'b0));
    tbl.push_back(idl(1'b0, 8'h00, 1'b0, 1'b0));
    // Test 3: address wrap FFFF -> 0000.
    tbl.push_back(idl(1'b1, 8'hA5, 1'b0, 1'b0));
    tbl.push_back(frm(8'hFF, 1'b0));
    tbl.push_back(frm(8'hFF, 1'b0));
    tbl.push_back(frm(8'h02, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h11, 1'b0));
    tbl.push_back(wrc(8'h22, 16'hFFFF, 8'h11, 1'b0));
    tbl.push_back(wrc(8'h33, 16'h0000, 8'h22, 1'b0));
    tbl.push_back(dne(1'b0));
    tbl.push_back(idl(1'b0, 8'h00, 1'b0, 1'b0));
    // Test 6: idle junk discarded, then LEN=0 frame.
    tbl.push_back(idl(1'b1, 8'h00, 1'b0, 1'b0));
    tbl.push_back(idl(1'b1, 8'h42, 1'b1, 1'b0));
    tbl.push_back(idl(1'b1, 8'hFF, 1'b0, 1'b0));
    tbl.push_back(idl(1'b1, 8'hA5, 1'b0, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(frm(8'h00, 1'b0));
    tbl.push_back(dne(1'b0));
    tbl.push_back(idl(1'b0, 8'h00, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      RxValid = tbl[i].v;
      RxData  = tbl[i].d;
      CpuWE   = tbl[i].cwe;
      #1;
      bus = tbl[i].we || !tbl[i].hold;
      chk($sformatf("row%0d", i),
          {MemWE, CpuHold, Done, Error, RxReady,
           bus ? MemAddress : 16'h0000, bus ? MemDataIn : 8'h00},
          {tbl[i].we, tbl[i].hold, tbl[i].done, tbl[i].err, tbl[i].rdy,
           bus ? tbl[i].addr : 16'h0000, bus ? tbl[i].din : 8'h00});
    end

    // Test 4: stall after the first of five data bytes -> timeout abort.
    for (int i = 0; i < 6; i++) send(t4[i]);
    @(negedge CLK);
    RxValid = 1'b0;
    #1;
    chk("t4_write", {MemWE, MemAddress, MemDataIn}, {1'b1, 16'h0200, 8'h01});
    wcnt = 0;
    dcnt = 0;
    for (int k = 0; k < T; k++) begin
      if (k > 0) begin
        @(negedge CLK);
        #1;
      end
      wcnt += int'(MemWE);
      dcnt += int'(Done);
      if (k == T - 1) chk("t4_hold_before", {63'd0, CpuHold}, 64'd1);
    end
    @(negedge CLK);
    #1;
    dcnt += int'(Done);
    chk("t4_abort", {CpuHold, Error, MemWE}, {1'b0, 1'b1, 1'b0});
    chk("t4_writes", 64'(wcnt), 64'd1);
    chk("t4_no_done", 64'(dcnt), 64'd0);

    // Test 5: reset right after the second data byte.
    for (int i = 0; i < 7; i++) send(t5[i]);
    @(negedge CLK);
    RxValid = 1'b0;
    #1;
    chk("t5_write", {MemWE, CpuHold, MemAddress, MemDataIn}, {1'b1, 1'b1, 16'h0101, 8'hD2});
    #1;
    RST_N = 1'b0;
    #1;
    chk("t5_reset", {CpuHold, MemWE, RxReady, Error}, {1'b0, 1'b0, 1'b0, 1'b0});
    CpuWE      = 1'b1;
    CpuAddress = 16'h0010;
    #1;
    chk("t5_pass", {MemWE, MemAddress, MemDataIn}, {1'b1, 16'h0010, 8'h5A});
    @(negedge CLK);
    CpuWE      = 1'b0;
    CpuAddress = 16'h1234;
    RST_N      = 1'b1;
    @(negedge CLK);
    #1;
    chk("t5_after", {CpuHold, Done, Error, RxReady, MemWE}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
